// File: rtl/half_adder.sv
// Half adder cell: one-bit sum and carry of two input bits.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder. Operands are captured in parallel and summed one
// bit per clock, LSB first, through a full adder made of two half_adder cells
// and an OR, with the carry held in a flop between bits. The result registers
// update only on completion and hold until the next completion.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] s_sr_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;

    logic             ha0_sum_s;
    logic             ha0_carry_s;
    logic             bit_sum_s;
    logic             ha1_carry_s;
    logic             carry_next_s;
    logic             last_s;
    logic             accept_s;

    // First half adder: operand bits.
    half_adder u_ha0 (
        .a     (a_sr_r[0]),
        .b     (b_sr_r[0]),
        .sum   (ha0_sum_s),
        .carry (ha0_carry_s)
    );

    // Second half adder: partial sum plus the carry fed back from the previous bit.
    half_adder u_ha1 (
        .a     (ha0_sum_s),
        .b     (carry_r),
        .sum   (bit_sum_s),
        .carry (ha1_carry_s)
    );

    assign carry_next_s = ha0_carry_s | ha1_carry_s;
    assign last_s       = (state_r == RUN) && (cnt_r == CW'(WIDTH - 1));
    // A new operation is accepted exactly when the FSM enters RUN from outside RUN.
    assign accept_s     = (state_s == RUN) && (state_r != RUN);

    // Next-state logic: start accepted from IDLE or DONE, RUN lasts WIDTH bits.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_in) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (start_in) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register and registered status outputs decoded from the next state.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r  <= IDLE;
            busy_out <= 1'b0;
            done_out <= 1'b0;
        end else begin
            state_r  <= state_s;
            busy_out <= (state_s == RUN);
            done_out <= (state_s == DONE);
        end
    end

    // Datapath: load on accept, shift one bit per RUN cycle, publish result on the last bit.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            a_sr_r    <= {WIDTH{1'b0}};
            b_sr_r    <= {WIDTH{1'b0}};
            s_sr_r    <= {WIDTH{1'b0}};
            carry_r   <= 1'b0;
            cnt_r     <= {CW{1'b0}};
            sum_out   <= {WIDTH{1'b0}};
            carry_out <= 1'b0;
        end else if (accept_s) begin
            a_sr_r  <= a_in;
            b_sr_r  <= b_in;
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else if (state_r == RUN) begin
            a_sr_r  <= {1'b0, a_sr_r[WIDTH-1:1]};
            b_sr_r  <= {1'b0, b_sr_r[WIDTH-1:1]};
            s_sr_r  <= {bit_sum_s, s_sr_r[WIDTH-1:1]};
            carry_r <= carry_next_s;
            cnt_r   <= cnt_r + CW'(1);
            if (last_s) begin
                sum_out   <= {bit_sum_s, s_sr_r[WIDTH-1:1]};
                carry_out <= carry_next_s;
            end else begin
                sum_out   <= sum_out;
                carry_out <= carry_out;
            end
        end else begin
            a_sr_r <= a_sr_r;
            b_sr_r <= b_sr_r;
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: hand-computed vector table, reset and
// abort sequences, back-to-back operation and random operands checked against
// plain integer addition.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk_in;
    logic         rst_in;
    logic         start_in;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy_out;
    logic         done_out;
    logic [W-1:0] sum_out;
    logic         carry_out;

    int n_cmp;
    int n_err;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] s;
        logic         c;
    } vec_t;

    vec_t vecs[7];

    serial_adder #(.WIDTH(W)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .start_in  (start_in),
        .a_in      (a_in),
        .b_in      (b_in),
        .busy_out  (busy_out),
        .done_out  (done_out),
        .sum_out   (sum_out),
        .carry_out (carry_out)
    );

    // Free-running clock.
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Launch one operation and follow it to its done pulse (bounded).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke,
                          output logic [W-1:0] s, output logic c, output int lat,
                          output int busy_n, output bit hold_ok);
        logic [W-1:0] prev_s;
        logic         prev_c;
        prev_s  = sum_out;
        prev_c  = carry_out;
        hold_ok = 1'b1;
        busy_n  = 0;
        lat     = -1;
        a_in     = a;
        b_in     = b;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        for (int e = 0; e <= 3 * W; e++) begin
            if (busy_out) busy_n++;
            if (done_out) begin
                lat = e;
                break;
            end
            if (sum_out !== prev_s || carry_out !== prev_c) hold_ok = 1'b0;
            start_in = poke && (e == 2);
            a_in     = W'($urandom);
            b_in     = W'($urandom);
            tick();
        end
        start_in = 1'b0;
        s = sum_out;
        c = carry_out;
    endtask

    // Run one operation and compare it with the arithmetic sum and the timing rules.
    task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit poke);
        logic [W-1:0] s;
        logic         c;
        int           lat;
        int           busy_n;
        bit           hold_ok;
        logic [W:0]   expect_v;
        expect_v = {1'b0, a} + {1'b0, b};
        run_op(a, b, poke, s, c, lat, busy_n, hold_ok);
        check({name, " result"}, 64'({c, s}), 64'(expect_v));
        check({name, " latency"}, 64'(lat), 64'(W));
        check({name, " busy cycles"}, 64'(busy_n), 64'(W));
        check({name, " hold during run"}, 64'(hold_ok), 64'd1);
        tick();
        check({name, " idle after done"}, 64'({done_out, busy_out}), 64'd0);
    endtask

    initial begin
        logic [W-1:0] pa[4];
        logic [W-1:0] pb[4];
        logic [W:0]   e_v;
        int           dones;

        n_cmp = 0;
        n_err = 0;

        vecs[0] = '{a: 8'h0F, b: 8'h01, s: 8'h10, c: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, s: 8'h00, c: 1'b1};
        vecs[2] = '{a: 8'hFF, b: 8'hFF, s: 8'hFE, c: 1'b1};
        vecs[3] = '{a: 8'hAA, b: 8'h55, s: 8'hFF, c: 1'b0};
        vecs[4] = '{a: 8'h00, b: 8'h00, s: 8'h00, c: 1'b0};
        vecs[5] = '{a: 8'h80, b: 8'h80, s: 8'h00, c: 1'b1};
        vecs[6] = '{a: 8'h7F, b: 8'h01, s: 8'h80, c: 1'b0};

        // Reset with start held high: reset wins, nothing starts.
        rst_in   = 1'b1;
        start_in = 1'b1;
        a_in     = 8'h12;
        b_in     = 8'h34;
        tick();
        tick();
        check("reset outputs", 64'({busy_out, done_out, carry_out, sum_out}), 64'd0);
        rst_in   = 1'b0;
        start_in = 1'b0;
        tick();
        check("no start after reset", 64'({busy_out, done_out, carry_out, sum_out}), 64'd0);

        // Table-driven vectors; the first one also pokes start mid-run.
        for (int i = 0; i < 7; i++) begin
            logic [W-1:0] s;
            logic         c;
            int           lat;
            int           busy_n;
            bit           hold_ok;
            run_op(vecs[i].a, vecs[i].b, (i == 0), s, c, lat, busy_n, hold_ok);
            check($sformatf("vec%0d sum", i), 64'(s), 64'(vecs[i].s));
            check($sformatf("vec%0d carry", i), 64'(c), 64'(vecs[i].c));
            check($sformatf("vec%0d latency", i), 64'(lat), 64'(W));
            check($sformatf("vec%0d busy cycles", i), 64'(busy_n), 64'(W));
            check($sformatf("vec%0d hold", i), 64'(hold_ok), 64'd1);
            tick();
            check($sformatf("vec%0d idle after", i), 64'({done_out, busy_out}), 64'd0);
        end

        // Back-to-back with start held high and operands churning mid-run.
        pa = '{8'h0F, 8'hFF, 8'h3C, 8'h81};
        pb = '{8'h01, 8'hFF, 8'hC4, 8'h7F};
        start_in = 1'b1;
        a_in     = pa[0];
        b_in     = pb[0];
        tick();
        for (int j = 0; j < 4; j++) begin
            for (int e = 1; e <= W; e++) begin
                a_in = W'($urandom);
                b_in = W'($urandom);
                tick();
            end
            e_v = {1'b0, pa[j]} + {1'b0, pb[j]};
            check($sformatf("b2b%0d done", j), 64'({done_out, busy_out}), 64'b10);
            check($sformatf("b2b%0d result", j), 64'({carry_out, sum_out}), 64'(e_v));
            if (j < 3) begin
                a_in = pa[j + 1];
                b_in = pb[j + 1];
            end else begin
                start_in = 1'b0;
            end
            tick();
        end
        check("b2b idle after", 64'({done_out, busy_out}), 64'd0);

        // Reset during the fourth RUN cycle aborts the operation.
        a_in     = 8'hAA;
        b_in     = 8'h55;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        tick();
        tick();
        tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check("abort outputs", 64'({busy_out, done_out, carry_out, sum_out}), 64'd0);
        dones = 0;
        for (int e = 0; e < 2 * W; e++) begin
            if (done_out || busy_out) dones++;
            tick();
        end
        check("abort no done", 64'(dones), 64'd0);
        do_op("after abort", 8'hAA, 8'h55, 1'b0);

        // Random operands against integer addition.
        for (int i = 0; i < 1000; i++) begin
            do_op("rand", W'($urandom), W'($urandom), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
